// File: rtl/div16_seq_pkg.sv
// Shared constants and carry-lookahead helpers for the sequential divider.
package div16_seq_pkg;

    localparam int WIDTH = 16;  // operand width; the adder is fixed at 16 bits
    localparam int CNT_W = 4;   // iteration counter width, log2(WIDTH)

    // FSM encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Quotient reported on divide-by-zero
    localparam logic [WIDTH-1:0] DBZ_QUOT = 16'hFFFF;

    // Last iteration index loaded into the counter on an accepted start
    localparam logic [CNT_W-1:0] CNT_LAST = 4'(WIDTH - 1);

    // Carries into each bit of a 4-bit lookahead block, c[0] is the carry-in.
    function automatic logic [3:0] cla_carries(input logic [3:0] g,
                                               input logic [3:0] p,
                                               input logic       c0);
        logic [3:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    // Block generate of a 4-bit lookahead block.
    function automatic logic cla_group_g(input logic [3:0] g,
                                         input logic [3:0] p);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

endpackage

// File: rtl/div16_seq_add16.sv
// Two-level 16-bit carry-lookahead adder: four 4-bit blocks plus a
// second-level lookahead unit over the block generate/propagate signals.
module add16
    import div16_seq_pkg::*;
(
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] sum_o,
    output logic        cout_o
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  grp_g;
    logic [3:0]  grp_p;
    logic [3:0]  grp_c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // First level: per-block generate/propagate and in-block carries
    for (genvar j = 0; j < 4; j++) begin : g_blk
        assign grp_g[j]     = cla_group_g(g[4*j +: 4], p[4*j +: 4]);
        assign grp_p[j]     = &p[4*j +: 4];
        assign c[4*j +: 4]  = cla_carries(g[4*j +: 4], p[4*j +: 4], grp_c[j]);
    end

    // Second level: carries into each block and the final carry-out
    assign grp_c  = cla_carries(grp_g, grp_p, cin_i);
    assign cout_o = cla_group_g(grp_g, grp_p) | ((&grp_p) & cin_i);
    assign sum_o  = p ^ c;

endmodule

// File: rtl/div16_seq.sv
// Sequential 16-bit unsigned restoring divider. One trial subtraction per
// cycle through the shared CLA adder used as A + ~B + 1.
module div16_seq
    import div16_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  dividend,
    input  logic [WIDTH-1:0]  divisor,
    output logic              busy,
    output logic              done,
    output logic              dbz,
    output logic [WIDTH-1:0]  quotient,
    output logic [WIDTH-1:0]  remainder
);

    logic [1:0]       state_q,     state_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic [WIDTH-1:0] rem_acc_q,   rem_acc_d;
    logic [WIDTH-1:0] quo_acc_q,   quo_acc_d;
    logic [WIDTH-1:0] divisor_q,   divisor_d;
    logic [WIDTH-1:0] quotient_q,  quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q,       dbz_d;

    // Datapath for one restoring step
    logic [WIDTH:0]   shifted;     // {rem_acc, next dividend bit}
    logic [WIDTH-1:0] divisor_n;
    logic [WIDTH-1:0] trial;
    logic             no_borrow;
    logic             ok;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

    assign shifted   = {rem_acc_q, quo_acc_q[WIDTH-1]};
    assign divisor_n = ~divisor_q;

    add16 u_sub (
        .a_i    (shifted[WIDTH-1:0]),
        .b_i    (divisor_n),
        .cin_i  (1'b1),
        .sum_o  (trial),
        .cout_o (no_borrow)
    );

    // A set top bit means the shifted value already exceeds any 16-bit
    // divisor, so the subtraction succeeds even though the adder sees only
    // the low 16 bits; the truncated difference is then exact.
    assign ok       = no_borrow | shifted[WIDTH];
    assign rem_step = ok ? trial : shifted[WIDTH-1:0];
    assign quo_step = {quo_acc_q[WIDTH-2:0], ok};

    // Next-state logic: operand capture, iteration, result load on DONE entry
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_acc_d   = rem_acc_q;
        quo_acc_d   = quo_acc_q;
        divisor_d   = divisor_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        state_d     = S_DONE;
                        quotient_d  = DBZ_QUOT;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d   = S_RUN;
                        rem_acc_d = '0;
                        quo_acc_d = dividend;
                        divisor_d = divisor;
                        count_d   = CNT_LAST;
                        dbz_d     = 1'b0;
                    end
                end
            end
            S_RUN: begin
                rem_acc_d = rem_step;
                quo_acc_d = quo_step;
                if (count_q == '0) begin
                    state_d     = S_DONE;
                    quotient_d  = quo_step;
                    remainder_d = rem_step;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset discarding any partial result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            rem_acc_q   <= '0;
            quo_acc_q   <= '0;
            divisor_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_acc_q   <= rem_acc_d;
            quo_acc_q   <= quo_acc_d;
            divisor_q   <= divisor_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    // Status decoded straight from the state register, so busy and done
    // are mutually exclusive by construction
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign dbz       = dbz_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_div16_seq.sv
// Directed-vector and random-sweep bench for the sequential divider.
module tb_div16_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        busy, done, dbz;
    logic [15:0] quotient, remainder;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
    } vec_t;

    vec_t vt[12];

    div16_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .dbz       (dbz),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Pulse start for one edge from a negedge; returns #1 after the accepting edge
    // with operand inputs scrambled to show they are not re-sampled.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
    endtask

    // Full operation: latency, busy window, results, single-cycle done, hold
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eq, input logic [15:0] er, input logic ez);
        int done_at;
        int busy_cnt;
        int overlap;
        done_at  = 0;
        busy_cnt = 0;
        overlap  = 0;
        start_op(a, b);
        for (int c = 1; c <= 40 && done_at == 0; c++) begin
            @(negedge clk);
            if (busy && done) overlap++;
            if (done) done_at = c;
            else if (busy) busy_cnt++;
        end
        chk({tag, "_latency"}, 32'(done_at), ez ? 32'd1 : 32'd17);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), ez ? 32'd0 : 32'd16);
        chk({tag, "_busy_done_overlap"}, 32'(overlap), 32'd0);
        chk({tag, "_quotient"}, 32'(quotient), 32'(eq));
        chk({tag, "_remainder"}, 32'(remainder), 32'(er));
        chk({tag, "_dbz"}, 32'(dbz), 32'(ez));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_hold_q"}, 32'(quotient), 32'(eq));
    endtask

    initial begin
        vt[0]  = '{16'd100,   16'd7,      16'd14,    16'd2,      1'b0};
        vt[1]  = '{16'hFFFF,  16'h8000,   16'd1,     16'h7FFF,   1'b0};
        vt[2]  = '{16'hFFFF,  16'h0001,   16'hFFFF,  16'h0000,   1'b0};
        vt[3]  = '{16'd5,     16'd0,      16'hFFFF,  16'd5,      1'b1};
        vt[4]  = '{16'd9,     16'd3,      16'd3,     16'd0,      1'b0};
        vt[5]  = '{16'd0,     16'd5,      16'd0,     16'd0,      1'b0};
        vt[6]  = '{16'd7,     16'd9,      16'd0,     16'd7,      1'b0};
        vt[7]  = '{16'hFFFF,  16'hFFFF,   16'd1,     16'd0,      1'b0};
        vt[8]  = '{16'hFFFE,  16'hFFFF,   16'd0,     16'hFFFE,   1'b0};
        vt[9]  = '{16'h8000,  16'd3,      16'h2AAA,  16'd2,      1'b0};
        vt[10] = '{16'hC000,  16'h8001,   16'd1,     16'h3FFF,   1'b0};
        vt[11] = '{16'd0,     16'd0,      16'hFFFF,  16'd0,      1'b1};

        // Reset state while reset is held
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dbz", 32'(dbz), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].z);

        // Start pulse during RUN with other operands, then start during DONE
        begin
            int done_at;
            int extra;
            done_at = 0;
            extra   = 0;
            start_op(16'd1000, 16'd10);
            for (int c = 1; c <= 40 && done_at == 0; c++) begin
                @(negedge clk);
                if (done) done_at = c;
                else if (c == 5) begin
                    start = 1'b1; dividend = 16'd3; divisor = 16'd1;
                    @(posedge clk);
                    #1 start = 1'b0; dividend = 16'd77; divisor = 16'd0;
                end
            end
            chk("ignore_run_latency", 32'(done_at), 32'd17);
            chk("ignore_run_quotient", 32'(quotient), 32'd100);
            chk("ignore_run_remainder", 32'(remainder), 32'd0);
            start = 1'b1; dividend = 16'd3; divisor = 16'd1;
            @(posedge clk);
            #1 start = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (busy || done) extra++;
            end
            chk("ignore_done_activity", 32'(extra), 32'd0);
            chk("ignore_done_quotient", 32'(quotient), 32'd100);
        end

        // Reset mid-RUN discards the operation; results held until then
        run_op("pre_rst_dbz", 16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1);
        start_op(16'hFFFF, 16'h0001);
        repeat (8) @(negedge clk);
        chk("midrun_busy", 32'(busy), 32'd1);
        chk("midrun_hold_q", 32'(quotient), 32'hFFFF);
        chk("midrun_hold_r", 32'(remainder), 32'd5);
        rst = 1'b1;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        chk("async_rst_dbz", 32'(dbz), 32'd0);
        chk("async_rst_quotient", 32'(quotient), 32'd0);
        chk("async_rst_remainder", 32'(remainder), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("post_rst", 16'h1234, 16'h0010, 16'h0123, 16'd4, 1'b0);

        // Random sweep against a reference model
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] a, b, eq, er;
            logic        ez;
            a = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       b = 16'($urandom_range(1, 15));
                1:       b = 16'($urandom_range(0, 255));
                default: b = 16'($urandom);
            endcase
            if ($urandom_range(0, 49) == 0) b = '0;
            if (b == '0) begin
                eq = 16'hFFFF; er = a; ez = 1'b1;
            end else begin
                eq = a / b; er = a % b; ez = 1'b0;
            end
            run_op($sformatf("rnd%0d", i), a, b, eq, er, ez);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
